// File: rtl/sinewave_pkg.sv
// Shared definitions for the sine-wave DAC/ADC chain: converter resolution
// and the SAR controller state encoding.
package sinewave_pkg;

    localparam int ADC_NBITS = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } adc_state_e;

endpackage

// File: rtl/sar_register.sv
// Successive-approximation register: the trial code plus a one-hot pointer
// to the bit currently under test.
module sar_register
    import sinewave_pkg::*;
#(
    parameter int NBITS = ADC_NBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load_msb,
    input  logic             step,
    input  logic             cmp,
    output logic [NBITS-1:0] code,
    output logic             last_bit
);

    localparam logic [NBITS-1:0] MSB_ONEHOT = {1'b1, {(NBITS-1){1'b0}}};

    logic [NBITS-1:0] code_q, code_d;
    logic [NBITS-1:0] ptr_q, ptr_d;

    // A step resolves the bit under test and raises the next lower trial bit;
    // after the LSB the pointer rewinds to the MSB, ready for the next run.
    always_comb begin
        code_d = code_q;
        ptr_d  = ptr_q;
        if (clear) begin
            code_d = '0;
            ptr_d  = MSB_ONEHOT;
        end else if (load_msb) begin
            code_d = MSB_ONEHOT;
            ptr_d  = MSB_ONEHOT;
        end else if (step) begin
            code_d = (cmp ? code_q : (code_q & ~ptr_q)) | (ptr_q >> 1);
            ptr_d  = ptr_q[0] ? MSB_ONEHOT : (ptr_q >> 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
            ptr_q  <= MSB_ONEHOT;
        end else begin
            code_q <= code_d;
            ptr_q  <= ptr_d;
        end
    end

    assign code     = code_q;
    assign last_bit = ptr_q[0];

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR ADC controller: tracks for SAMPLE_TICKS en ticks, then resolves one bit
// per en tick against an external DAC and comparator.
module sar_adc_ctrl
    import sinewave_pkg::*;
#(
    parameter int NBITS        = ADC_NBITS,
    parameter int SAMPLE_TICKS = 4,
    parameter bit CONTINUOUS   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic             cmp_in,
    output logic [NBITS-1:0] dac_code,
    output logic             sample,
    output logic             busy,
    output logic [NBITS-1:0] data,
    output logic             data_valid
);

    localparam int TW = (SAMPLE_TICKS > 1) ? $clog2(SAMPLE_TICKS) : 1;

    adc_state_e       state_q, state_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic             sample_q, sample_d;
    logic             busy_q, busy_d;
    logic [NBITS-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    logic             go;
    logic             last_tick;
    logic             sar_clear, sar_load, sar_step;
    logic             last_bit;

    assign go        = start || CONTINUOUS;
    assign last_tick = (tick_q == TW'(SAMPLE_TICKS - 1));

    sar_register #(.NBITS(NBITS)) u_sar (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (sar_clear),
        .load_msb (sar_load),
        .step     (sar_step),
        .cmp      (cmp_in),
        .code     (dac_code),
        .last_bit (last_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            tick_q   <= '0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (go) state_d = ST_SAMPLE;
            ST_SAMPLE:  if (en && last_tick) state_d = ST_CONVERT;
            ST_CONVERT: if (en && last_bit) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tick_d    = tick_q;
        sample_d  = sample_q;
        busy_d    = busy_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        sar_clear = 1'b0;
        sar_load  = 1'b0;
        sar_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    busy_d    = 1'b1;
                    sample_d  = 1'b1;
                    tick_d    = '0;
                    sar_clear = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (en) begin
                    tick_d = tick_q + 1'b1;
                    if (last_tick) begin
                        sample_d = 1'b0;
                        sar_load = 1'b1;
                    end
                end
            end
            ST_CONVERT: begin
                if (en) begin
                    sar_step = 1'b1;
                    // The LSB decision is folded in directly; the register
                    // only catches up on the same edge.
                    if (last_bit) begin
                        data_d  = {dac_code[NBITS-1:1], cmp_in};
                        valid_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d   = 1'b0;
                sample_d = 1'b0;
            end
        endcase
    end

    assign sample     = sample_q;
    assign busy       = busy_q;
    assign data       = data_q;
    assign data_valid = valid_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Loop-back bench: ideal DAC + comparator around two controllers (one-shot
// and continuous). Vin is expressed in 1/16 LSB units (VREF = 4096*16).
module tb_sar_adc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic        en_hold = 1'b0;
    int          div = 0;
    int          total = 0;
    int          bad = 0;

    int          vin1 = 0;
    int          vin2 = 0;
    int          vheld2 = 0;
    logic        cmp1, cmp2;
    logic [11:0] dac1, dac2, data1, data2;
    logic        sample1, sample2, busy1, busy2, dv1, dv2;

    always #5 clk = ~clk;

    // en tick every third clock, suppressible for stall tests
    always @(negedge clk) begin
        if (div == 2) div = 0;
        else div = div + 1;
        en = !en_hold && (div == 0);
    end

    always @(posedge clk) if (sample2) vheld2 <= vin2;

    assign cmp1 = (vin1 >= int'({20'd0, dac1}) * 16);
    assign cmp2 = (vheld2 >= int'({20'd0, dac2}) * 16);

    sar_adc_ctrl #(.NBITS(12), .SAMPLE_TICKS(4), .CONTINUOUS(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .cmp_in(cmp1),
        .dac_code(dac1), .sample(sample1), .busy(busy1), .data(data1), .data_valid(dv1)
    );

    sar_adc_ctrl #(.NBITS(12), .SAMPLE_TICKS(4), .CONTINUOUS(1'b1)) dut_cont (
        .clk(clk), .rst_n(rst_n), .en(en), .start(1'b0), .cmp_in(cmp2),
        .dac_code(dac2), .sample(sample2), .busy(busy2), .data(data2), .data_valid(dv2)
    );

    typedef struct {
        string       nm;
        int          vin;
        logic [11:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_conv(input string nm, input int vin, input int restart_at,
                            input int stall_at, output int samp_ticks,
                            output int conv_ticks, output int dv_cnt,
                            output logic [11:0] res);
        logic        prev_sample;
        logic [11:0] fz_code;
        logic        fz_sample;
        bit          done = 0;
        bit          stalled = 0;
        bit          fz_err = 0;
        samp_ticks = 0;
        conv_ticks = 0;
        dv_cnt     = 0;
        res        = '0;
        vin1 = vin;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, "_accept_busy"}, busy1, 1);
        prev_sample = sample1;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clk); #1;
            if (en) begin
                if (prev_sample) samp_ticks++;
                else conv_ticks++;
            end
            prev_sample = sample1;
            if (dv1) begin
                dv_cnt++;
                res  = data1;
                done = 1;
            end
            if (restart_at >= 0 && conv_ticks == restart_at && !done) start = 1'b1;
            else start = 1'b0;
            if (stall_at >= 0 && conv_ticks == stall_at && !stalled && !done) begin
                stalled   = 1;
                fz_code   = dac1;
                fz_sample = sample1;
                en_hold   = 1'b1;
                repeat (500) begin
                    @(posedge clk); #1;
                    if (dac1 !== fz_code || sample1 !== fz_sample || busy1 !== 1'b1 || dv1 !== 1'b0)
                        fz_err = 1;
                end
                en_hold = 1'b0;
                chk({nm, "_stall_frozen"}, fz_err, 0);
            end
        end
        start = 1'b0;
        if (!done) chk({nm, "_timeout"}, 0, 1);
        repeat (60) begin
            @(posedge clk); #1;
            if (dv1) dv_cnt++;
        end
        chk({nm, "_busy_after"}, busy1, 0);
    endtask

    initial begin
        int          st, ct, dv, t, cnt, last_cyc, interval, events, since;
        logic [11:0] res, prev_data;
        bit          got;

        vecs[0] = '{"half_scale",  32768, 12'h800};
        vecs[1] = '{"zero",            0, 12'h000};
        vecs[2] = '{"full_scale",  65536, 12'hFFF};
        vecs[3] = '{"code_1000",   16000, 12'd1000};
        vecs[4] = '{"code_1000_f", 16015, 12'd1000};
        vecs[5] = '{"code_999",    15999, 12'd999};
        vecs[6] = '{"one_lsb",        16, 12'd1};
        vecs[7] = '{"near_full",   65535, 12'hFFF};

        repeat (3) @(negedge clk);
        chk("rst_dac_code", dac1, 0);
        chk("rst_sample", sample1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_data", data1, 0);
        chk("rst_data_valid", dv1, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_start_busy", busy1, 0);

        // basic conversions, including exact-threshold and saturation cases
        for (int i = 0; i < 8; i++) begin
            run_conv(vecs[i].nm, vecs[i].vin, -1, -1, st, ct, dv, res);
            chk({vecs[i].nm, "_data"}, res, vecs[i].exp_data);
            chk({vecs[i].nm, "_dv_count"}, dv, 1);
            chk({vecs[i].nm, "_sample_ticks"}, st, 4);
            chk({vecs[i].nm, "_convert_ticks"}, ct, 12);
            chk({vecs[i].nm, "_data_held"}, data1, vecs[i].exp_data);
            chk({vecs[i].nm, "_dac_holds_result"}, dac1, vecs[i].exp_data);
        end

        // start re-pulsed mid-CONVERT must be ignored
        run_conv("restart", 32768, 5, -1, st, ct, dv, res);
        chk("restart_data", res, 12'h800);
        chk("restart_dv_count", dv, 1);
        chk("restart_latency_ticks", st + ct, 16);

        // long en stall mid-CONVERT
        run_conv("stall", 32768, -1, 6, st, ct, dv, res);
        chk("stall_data", res, 12'h800);
        chk("stall_dv_count", dv, 1);
        chk("stall_convert_ticks", ct, 12);

        // asynchronous reset mid-CONVERT
        vin1 = 16000;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        for (int c = 0; c < 200 && t < 12; c++) begin
            @(posedge clk); #1;
            if (en) t++;
        end
        chk("abort_reached_convert", t, 12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_dac_code", dac1, 0);
        chk("abort_sample", sample1, 0);
        chk("abort_busy", busy1, 0);
        chk("abort_data", data1, 0);
        chk("abort_data_valid", dv1, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (dv1 || busy1) cnt++;
        end
        chk("abort_no_activity", cnt, 0);
        run_conv("after_abort", 16000, -1, -1, st, ct, dv, res);
        chk("after_abort_data", res, 12'd1000);
        chk("after_abort_dv_count", dv, 1);

        // continuous mode with a slow ramp (1/16 LSB per clock)
        vin2 = 16000;
        events = 0;
        interval = 0;
        last_cyc = 0;
        since = 0;
        prev_data = '0;
        got = 0;
        for (int c = 0; c < 2000 && events < 6; c++) begin
            @(posedge clk); #1;
            vin2 = vin2 + 1;
            since++;
            if (got && since == 1) chk("cont_busy_drop", busy2, 0);
            if (got && since == 2) chk("cont_busy_restart", busy2, 1);
            if (dv2) begin
                if (events >= 1) chk("cont_monotonic", (data2 >= prev_data), 1);
                if (events == 1) interval = c - last_cyc;
                if (events >= 2) chk("cont_interval", c - last_cyc, interval);
                last_cyc  = c;
                prev_data = data2;
                events++;
                since = 0;
                got   = 1;
            end
        end
        chk("cont_event_count", events, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
